// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared op codes, FSM encodings and helpers for the MD scheduler
package md_sched_pkg;

  // MD op codes, shared with the ID-stage decoder
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Scheduler FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // True for the ops that occupy the unit for several cycles
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 64-bit multiply/divide result generator
module md_arith
  import md_sched_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_next_o,
  output logic [31:0] lo_next_o,
  output logic        div_zero_o
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        rs_mag;
  logic [31:0]        rt_mag;
  logic [31:0]        dvd;
  logic [31:0]        dvs;
  logic [31:0]        quo;
  logic [31:0]        rem;
  logic               is_div;

  // Signed divide runs on magnitudes through the same unsigned divider; a zero
  // divisor is replaced by 1 so the divider never sees X, the result is discarded anyway.
  always_comb begin
    is_div     = (op_i == MD_DIV) || (op_i == MD_DIVU);
    div_zero_o = is_div && (rt_i == 32'd0);
    prod_s     = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    prod_u     = {32'd0, rs_i} * {32'd0, rt_i};
    rs_mag     = rs_i[31] ? (32'd0 - rs_i) : rs_i;
    rt_mag     = rt_i[31] ? (32'd0 - rt_i) : rt_i;
    dvd        = (op_i == MD_DIV) ? rs_mag : rs_i;
    dvs        = (op_i == MD_DIV) ? rt_mag : rt_i;
    if (dvs == 32'd0) begin
      dvs = 32'd1;
    end
    quo        = dvd / dvs;
    rem        = dvd % dvs;
    hi_next_o  = 32'd0;
    lo_next_o  = 32'd0;
    case (op_i)
      MD_MULT: begin
        hi_next_o = prod_s[63:32];
        lo_next_o = prod_s[31:0];
      end
      MD_MULTU: begin
        hi_next_o = prod_u[63:32];
        lo_next_o = prod_u[31:0];
      end
      MD_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        // 0x80000000 / -1 wraps back to 0x80000000 here by two's-complement negation.
        lo_next_o = (rs_i[31] ^ rt_i[31]) ? (32'd0 - quo) : quo;
        hi_next_o = rs_i[31] ? (32'd0 - rem) : rem;
      end
      MD_DIVU: begin
        lo_next_o = quo;
        hi_next_o = rem;
      end
      default: begin
        hi_next_o = 32'd0;
        lo_next_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - EX-stage multiply/divide scheduler owning HI/LO and the MD stall
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_Ex,
  input  logic [2:0]  mdOp_Ex,
  input  logic [31:0] rs_Ex,
  input  logic [31:0] rt_Ex,
  input  logic        useMd_Id,
  output logic        busy,
  output logic        mdStall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_next_q, hi_next_d;
  logic [31:0]      lo_next_q, lo_next_d;
  logic             commit_q, commit_d;

  logic [31:0]      ar_hi;
  logic [31:0]      ar_lo;
  logic             ar_div_zero;

  md_arith u_arith (
    .op_i       (mdOp_Ex),
    .rs_i       (rs_Ex),
    .rt_i       (rt_Ex),
    .hi_next_o  (ar_hi),
    .lo_next_o  (ar_lo),
    .div_zero_o (ar_div_zero)
  );

  // FSM: capture the result at issue, count down, commit HI/LO on the last busy cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_next_d = hi_next_q;
    lo_next_d = lo_next_q;
    commit_d  = commit_q;
    if (state_q == ST_IDLE) begin
      if (start_Ex) begin
        case (mdOp_Ex)
          MD_MULT, MD_MULTU: begin
            hi_next_d = ar_hi;
            lo_next_d = ar_lo;
            commit_d  = 1'b1;
            cnt_d     = CNT_W'(MULT_CYCLES);
            state_d   = ST_RUN;
          end
          MD_DIV, MD_DIVU: begin
            // A zero divisor still occupies the unit but leaves HI/LO untouched
            hi_next_d = ar_hi;
            lo_next_d = ar_lo;
            commit_d  = !ar_div_zero;
            cnt_d     = CNT_W'(DIV_CYCLES);
            state_d   = ST_RUN;
          end
          MD_MTHI: hi_d = rs_Ex;
          MD_MTLO: lo_d = rs_Ex;
          default: ;
        endcase
      end
    end else begin
      // Ops arriving while running are ignored; the in-flight op owns the unit
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (commit_q) begin
          hi_d = hi_next_q;
          lo_d = lo_next_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers; reset aborts any op in flight without committing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_next_q <= '0;
      lo_next_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_next_q <= hi_next_d;
      lo_next_q <= lo_next_d;
      commit_q  <= commit_d;
    end
  end

  // Stall is combinational so an mfhi/mflo right behind a mult/div holds in ID on the issue cycle
  always_comb begin
    busy    = (state_q == ST_RUN);
    mdStall = useMd_Id & (busy | (start_Ex & is_muldiv(mdOp_Ex)));
    hi      = hi_q;
    lo      = lo_q;
  end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - self-checking bench for md_sched
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_Ex = 1'b0;
  logic [2:0]  mdOp_Ex = 3'd0;
  logic [31:0] rs_Ex = 32'd0;
  logic [31:0] rt_Ex = 32'd0;
  logic        useMd_Id = 1'b0;
  logic        busy_w;
  logic        stall_w;
  logic [31:0] hi_w;
  logic [31:0] lo_w;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_Ex (start_Ex),
    .mdOp_Ex  (mdOp_Ex),
    .rs_Ex    (rs_Ex),
    .rt_Ex    (rt_Ex),
    .useMd_Id (useMd_Id),
    .busy     (busy_w),
    .mdStall  (stall_w),
    .hi       (hi_w),
    .lo       (lo_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        use_md;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: architectural result of one op given the current HI/LO
  task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cyc);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cyc = 0;
    case (op)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; cyc = 5; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; cyc = 5; end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic apply(input string name, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic use_md, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_cyc);
    int cyc;
    logic stall_ok;
    @(negedge clk);
    start_Ex = 1'b1; mdOp_Ex = op; rs_Ex = rs; rt_Ex = rt; useMd_Id = use_md;
    #1;
    chk({name, ".stall_start"}, 64'(stall_w), 64'(use_md & (op <= 3'd3)));
    @(posedge clk); #1;
    start_Ex = 1'b0;
    cyc = 0;
    stall_ok = 1'b1;
    while (busy_w && cyc < 40) begin
      if (stall_w !== use_md) stall_ok = 1'b0;
      cyc++;
      @(posedge clk); #1;
    end
    if (stall_w !== 1'b0) stall_ok = 1'b0;
    chk({name, ".stall_busy"}, 64'(stall_ok), 64'd1);
    chk({name, ".busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({name, ".hi"}, 64'(hi_w), 64'(exp_hi));
    chk({name, ".lo"}, 64'(lo_w), 64'(exp_lo));
    useMd_Id = 1'b0;
  endtask

  // Issue while busy must never be generated by this bench
  always @(posedge clk) begin
    if (reset_n && start_Ex && busy_w) begin
      total++;
      $display("FAIL issue_while_busy: got start=1 busy=1 required start=0");
    end
  end

  initial begin
    vecs[0] = '{"mult_neg",   3'd0, 32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"divu_mflo",  3'd3, 32'd100,      32'd7,        1'b1, 32'd2,        32'd14,       10};
    vecs[2] = '{"div_neg",    3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000, 10};
    vecs[4] = '{"mthi",       3'd4, 32'h1234,     32'd9,        1'b1, 32'h1234,     32'h80000000, 0};
    vecs[5] = '{"div_zero",   3'd2, 32'd55,       32'd0,        1'b0, 32'h1234,     32'h80000000, 10};
    vecs[6] = '{"mtlo",       3'd5, 32'hABCD,     32'd0,        1'b0, 32'h1234,     32'hABCD,     0};
    vecs[7] = '{"undef_op",   3'd6, 32'h5555,     32'd3,        1'b1, 32'h1234,     32'hABCD,     0};

    #12;
    chk("reset.busy", 64'(busy_w), 64'd0);
    chk("reset.stall", 64'(stall_w), 64'd0);
    chk("reset.hi", 64'(hi_w), 64'd0);
    chk("reset.lo", 64'(lo_w), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].use_md,
            vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc);
    end

    // ID wants HI/LO but nothing is running or issuing
    @(negedge clk);
    useMd_Id = 1'b1; start_Ex = 1'b0;
    #1;
    chk("idle_use_no_start.stall", 64'(stall_w), 64'd0);
    useMd_Id = 1'b0;

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    start_Ex = 1'b1; mdOp_Ex = 3'd0; rs_Ex = 32'd5; rt_Ex = 32'd7;
    @(posedge clk); #1;
    start_Ex = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midop_reset.busy", 64'(busy_w), 64'd0);
    chk("midop_reset.hi", 64'(hi_w), 64'd0);
    chk("midop_reset.lo", 64'(lo_w), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply("multu_after_reset", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'd1, 5);
    m_hi = 32'hFFFFFFFE;
    m_lo = 32'd1;

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        u;
      int          cyc;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      u = 1'($urandom_range(0, 1));
      model_step(op, a, b, cyc);
      apply("random", op, a, b, u, m_hi, m_lo, cyc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
